// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared UART definitions: FSM state encoding and parity-mode constants,
// intended for reuse by the matching parametrised receiver.
package uart_tx_fifo_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/uart_tx_fifo_param_sync_fifo.sv
// Single-clock FIFO queueing bytes for the UART transmitter.
// Pointers wrap naturally; count is one bit wider so full and empty are unambiguous.
module uart_tx_fifo_param_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: storage has no reset; the count guarantees stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input FIFO; frames are sent
// back-to-back while data is queued.
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_e            state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 baud_tick;
    logic                 frame_end;
    logic                 load_parity;

    uart_tx_fifo_param_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_Clk),
        .rst_i     (i_Rst),
        .push_i    (i_Tx_DV),
        .pop_i     (fifo_pop),
        .wr_data_i (i_Tx_Byte),
        .rd_data_o (fifo_rd_data),
        .count_o   (o_Fifo_Count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign o_Tx_Ready  = !fifo_full;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

    assign baud_tick   = (baud_q == BAUD_LAST);
    assign frame_end   = (state_q == ST_STOP) && baud_tick && (bit_idx_q == STOP_LAST);
    // Pop from idle, or on the final stop cycle so the next frame follows with no gap.
    assign fifo_pop    = !fifo_empty && ((state_q == ST_IDLE) || frame_end);
    assign load_parity = (PARITY == PARITY_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            baud_q <= baud_tick ? '0 : baud_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    serial_q  <= 1'b1;
                    baud_q    <= '0;
                    bit_idx_q <= '0;
                end
                ST_START: begin
                    if (baud_tick) begin
                        state_q  <= ST_DATA;
                        serial_q <= shift_q[0];
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx_q == DATA_LAST) begin
                            bit_idx_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                state_q  <= ST_PARITY;
                                serial_q <= parity_q;
                            end else begin
                                state_q  <= ST_STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            serial_q  <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        state_q  <= ST_STOP;
                        serial_q <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (frame_end) begin
                        done_q    <= 1'b1;
                        bit_idx_q <= '0;
                        state_q   <= ST_IDLE;
                        active_q  <= 1'b0;
                        serial_q  <= 1'b1;
                    end else if (baud_tick) begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // A pop overrides the idle/stop handling above and starts a new frame.
            if (fifo_pop) begin
                shift_q   <= fifo_rd_data;
                parity_q  <= load_parity;
                state_q   <= ST_START;
                serial_q  <= 1'b0;
                active_q  <= 1'b1;
                baud_q    <= '0;
                bit_idx_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench: 8N1 FIFO/reset/ordering cases plus 8E1, 8O1 and 7E2 frames
// on separate instances sharing one clock and reset.
module tb_uart_tx_fifo_param;

    localparam int CPB = 87;

    logic       clk;
    logic       rst;
    logic [3:0] dv;
    logic [7:0] tx_byte;

    wire  [3:0] ser_v;
    wire  [3:0] act_v;
    wire  [3:0] done_v;
    wire  [3:0] rdy_v;
    wire  [2:0] cnt_v [4];

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(rdy_v[0]), .o_Fifo_Count(cnt_v[0]), .o_Tx_Active(act_v[0]),
        .o_Tx_Serial(ser_v[0]), .o_Tx_Done(done_v[0]));

    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(rdy_v[1]), .o_Fifo_Count(cnt_v[1]), .o_Tx_Active(act_v[1]),
        .o_Tx_Serial(ser_v[1]), .o_Tx_Done(done_v[1]));

    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(tx_byte),
        .o_Tx_Ready(rdy_v[2]), .o_Fifo_Count(cnt_v[2]), .o_Tx_Active(act_v[2]),
        .o_Tx_Serial(ser_v[2]), .o_Tx_Done(done_v[2]));

    uart_tx_fifo_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(tx_byte[6:0]),
        .o_Tx_Ready(rdy_v[3]), .o_Fifo_Count(cnt_v[3]), .o_Tx_Active(act_v[3]),
        .o_Tx_Serial(ser_v[3]), .o_Tx_Done(done_v[3]));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Push into an idle, empty transmitter; returns just after the edge the line drops.
    task automatic push_idle(input int sel, input logic [7:0] b, input string tag);
        @(negedge clk);
        dv[sel] = 1'b1;
        tx_byte = b;
        @(posedge clk); #1;
        dv[sel] = 1'b0;
        check({tag, "/queued"}, 32'(cnt_v[sel]), 32'd1);
        @(posedge clk); #1;
        check({tag, "/start"}, {act_v[sel], ser_v[sel]}, 32'b10);
        check({tag, "/popped"}, 32'(cnt_v[sel]), 32'd0);
    endtask

    // Push mid-frame: advances exactly one clock.
    task automatic push_now(input int sel, input logic [7:0] b);
        @(negedge clk);
        dv[sel] = 1'b1;
        tx_byte = b;
        @(posedge clk); #1;
        dv[sel] = 1'b0;
    endtask

    // Follows a frame from cycle c0 (0 = first START cycle) to one cycle past its
    // final stop cycle, sampling each bit at mid-bit. Optionally pushes a byte on
    // the stop-end edge.
    task automatic watch_frame(input int sel, input logic [11:0] bits, input int nbits,
                               input int c0, input logic more, input logic push_end,
                               input logic [7:0] pbyte, input string tag);
        int   last;
        logic early;
        last  = nbits * CPB;
        early = 1'b0;
        for (int c = c0; c < last; c++) begin
            if (c % CPB == CPB / 2)
                check($sformatf("%s/bit%0d", tag, c / CPB), {act_v[sel], ser_v[sel]}, {1'b1, bits[c / CPB]});
            if (c > 0 && done_v[sel]) early = 1'b1;
            if (push_end && c == last - 1) begin
                dv[sel] = 1'b1;
                tx_byte = pbyte;
            end
            @(posedge clk); #1;
        end
        dv[sel] = 1'b0;
        check({tag, "/no_early_done"}, 32'(early), 32'd0);
        check({tag, "/done"}, 32'(done_v[sel]), 32'd1);
        check({tag, "/line_after"}, {act_v[sel], ser_v[sel]}, more ? 32'b10 : 32'b01);
    endtask

    initial begin
        logic [2:0] exp_cnt [7];
        logic       exp_rdy [7];
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst     = 1'b1;
        dv      = '0;
        tx_byte = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/serial", 32'(ser_v[0]), 32'd1);
        check("reset/active", 32'(act_v[0]), 32'd0);
        check("reset/done",   32'(done_v[0]), 32'd0);
        check("reset/count",  32'(cnt_v[0]), 32'd0);
        check("reset/ready",  32'(rdy_v[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 8N1 single byte, then Done must drop after one cycle.
        push_idle(0, 8'hAB, "t1");
        watch_frame(0, {2'b00, 1'b1, 8'hAB, 1'b0}, 10, 0, 1'b0, 1'b0, 8'h00, "t1");
        @(posedge clk); #1;
        check("t1/done_pulse_end", 32'(done_v[0]), 32'd0);

        // 8E1 and 8O1: parity of 0xAB (five ones) is 1 even, 0 odd.
        push_idle(1, 8'hAB, "t2e");
        watch_frame(1, {1'b0, 1'b1, 1'b1, 8'hAB, 1'b0}, 11, 0, 1'b0, 1'b0, 8'h00, "t2e");
        push_idle(2, 8'hAB, "t2o");
        watch_frame(2, {1'b0, 1'b1, 1'b0, 8'hAB, 1'b0}, 11, 0, 1'b0, 1'b0, 8'h00, "t2o");

        // 7E2: 0x3F has six ones -> parity 0, two stop bits.
        push_idle(3, 8'h3F, "t3");
        watch_frame(3, {1'b0, 2'b11, 1'b0, 7'h3F, 1'b0}, 11, 0, 1'b0, 1'b0, 8'h00, "t3");

        // FIFO fill with DV held for 7 edges; 0x06/0x07 hit a full FIFO.
        @(negedge clk);
        dv[0]   = 1'b1;
        tx_byte = 8'h01;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            tx_byte = 8'(i + 2);
            check($sformatf("t4/count%0d", i), 32'(cnt_v[0]), 32'(exp_cnt[i]));
            check($sformatf("t4/ready%0d", i), 32'(rdy_v[0]), 32'(exp_rdy[i]));
        end
        dv[0] = 1'b0;
        watch_frame(0, {2'b00, 1'b1, 8'h01, 1'b0}, 10, 5, 1'b1, 1'b0, 8'h00, "t4f1");
        check("t4/count_after1", 32'(cnt_v[0]), 32'd3);
        watch_frame(0, {2'b00, 1'b1, 8'h02, 1'b0}, 10, 0, 1'b1, 1'b0, 8'h00, "t4f2");
        check("t4/count_after2", 32'(cnt_v[0]), 32'd2);
        watch_frame(0, {2'b00, 1'b1, 8'h03, 1'b0}, 10, 0, 1'b1, 1'b0, 8'h00, "t4f3");
        check("t4/count_after3", 32'(cnt_v[0]), 32'd1);
        watch_frame(0, {2'b00, 1'b1, 8'h04, 1'b0}, 10, 0, 1'b1, 1'b0, 8'h00, "t4f4");
        check("t4/count_after4", 32'(cnt_v[0]), 32'd0);
        watch_frame(0, {2'b00, 1'b1, 8'h05, 1'b0}, 10, 0, 1'b0, 1'b0, 8'h00, "t4f5");
        check("t4/count_end", 32'(cnt_v[0]), 32'd0);

        // Asynchronous reset in the middle of the data bits.
        push_idle(0, 8'h55, "t5");
        push_now(0, 8'h12);
        check("t5/queued", 32'(cnt_v[0]), 32'd1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5/rst_serial", 32'(ser_v[0]), 32'd1);
        check("t5/rst_active", 32'(act_v[0]), 32'd0);
        check("t5/rst_count",  32'(cnt_v[0]), 32'd0);
        check("t5/rst_ready",  32'(rdy_v[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        push_idle(0, 8'hAB, "t5b");
        watch_frame(0, {2'b00, 1'b1, 8'hAB, 1'b0}, 10, 0, 1'b0, 1'b0, 8'h00, "t5b");

        // Push on the same edge as the stop-end pop with one byte queued.
        push_idle(0, 8'h11, "t6");
        push_now(0, 8'h22);
        watch_frame(0, {2'b00, 1'b1, 8'h11, 1'b0}, 10, 1, 1'b1, 1'b1, 8'h33, "t6a");
        check("t6/count_same_edge", 32'(cnt_v[0]), 32'd1);
        watch_frame(0, {2'b00, 1'b1, 8'h22, 1'b0}, 10, 0, 1'b1, 1'b0, 8'h00, "t6b");
        check("t6/count_b", 32'(cnt_v[0]), 32'd0);
        watch_frame(0, {2'b00, 1'b1, 8'h33, 1'b0}, 10, 0, 1'b0, 1'b0, 8'h00, "t6c");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
